// File: rtl/mvt_pkg.sv
// mvt_pkg: shared power-state encoding and default sizing for the multi-lane datapath
package mvt_pkg;
    typedef enum logic [1:0] {RUN, SLEEP, WAKE} pwr_state_t;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_IDLE_THRESH = 16;
endpackage

// File: rtl/mvt_pipe_stage.sv
// mvt_pipe_stage: one stall-all pipeline register holding NUM_CH lanes of valid + data
//   clk, rst_n          clock, synchronous active-low reset (clears valid and data)
//   en                  load enable, common to every stage
//   in_valid, in_data   contents of the previous stage
//   out_valid, out_data registered contents of this stage
module mvt_pipe_stage
    import mvt_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end
endmodule

// File: rtl/mvt_multich_datapath.sv
// mvt_multich_datapath: per-lane offset adder feeding a stall-all pipeline, with idle-driven sleep control
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_data     per-lane input beat; in_ready is the shared accept
//   cfg_we, cfg_ch, cfg_offset  offset register write port
//   out_valid, out_data   registered per-lane results; out_ready is the downstream accept
//   sleep_en, sleep_req   sleep permission and registered power-switch request
//   busy                  some pipeline stage holds a valid lane
module mvt_multich_datapath
    import mvt_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PIPE_STAGES = 2,
    parameter int IDLE_THRESH = DEF_IDLE_THRESH,
    parameter int WAKE_CYCLES = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [DATA_W-1:0]        cfg_offset,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     out_ready,
    input  logic                     sleep_en,
    output logic                     sleep_req,
    output logic                     busy
);
    localparam int IW = $clog2(IDLE_THRESH + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_THRESH);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESH - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic [CH_W:0] CH_NUM    = (CH_W + 1)'(NUM_CH);
    pwr_state_t state, state_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic [WW-1:0] wake_cnt, wake_n;
    logic adv, idle;
    logic [DATA_W-1:0] offset [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] sum;
    logic [NUM_CH-1:0] sv [PIPE_STAGES+1];
    logic [NUM_CH*DATA_W-1:0] sd [PIPE_STAGES+1];
    assign adv       = !(|out_valid) || out_ready;
    assign in_ready  = adv && (state == RUN);
    assign idle      = !(|in_valid) && !busy;
    assign sv[0]     = in_valid & {NUM_CH{in_ready}};
    assign sd[0]     = sum;
    assign out_valid = sv[PIPE_STAGES];
    assign out_data  = sd[PIPE_STAGES];
    // Offsets are read combinationally, so a beat accepted on the write edge still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) offset[k] <= '0;
        end else if (cfg_we && {1'b0, cfg_ch} < CH_NUM) begin
            offset[cfg_ch] <= cfg_offset;
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_add
        assign sum[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W] + offset[i];
    end
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        mvt_pipe_stage #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .in_valid  (sv[s]),
            .in_data   (sd[s]),
            .out_valid (sv[s+1]),
            .out_data  (sd[s+1])
        );
    end
    always_comb begin
        busy = 1'b0;
        for (int k = 1; k <= PIPE_STAGES; k++) busy = busy | (|sv[k]);
    end
    // The idle count saturates, so once it passes IDLE_THRESH-1 with sleep_en low,
    // sleep is only reachable again after some activity restarts the count.
    always_comb begin
        state_n = state;
        idle_n  = idle_cnt;
        wake_n  = wake_cnt;
        case (state)
            RUN: begin
                idle_n = idle ? ((idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + IW'(1)) : '0;
                if (idle && sleep_en && idle_cnt == IDLE_LAST) state_n = SLEEP;
            end
            SLEEP: begin
                if (|in_valid || !sleep_en) begin
                    state_n = WAKE;
                    wake_n  = '0;
                end
            end
            WAKE: begin
                wake_n = wake_cnt + WW'(1);
                if (wake_cnt == WAKE_LAST) begin
                    state_n = RUN;
                    idle_n  = '0;
                    wake_n  = '0;
                end
            end
            default: state_n = RUN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            idle_cnt  <= '0;
            wake_cnt  <= '0;
            sleep_req <= 1'b0;
        end else begin
            state     <= state_n;
            idle_cnt  <= idle_n;
            wake_cnt  <= wake_n;
            sleep_req <= (state_n == SLEEP);
        end
    end
endmodule

// File: tb/tb_mvt_multich_datapath.sv
// tb_mvt_multich_datapath: randomized and directed scoreboard bench for mvt_multich_datapath
module tb_mvt_multich_datapath;
    localparam int NCH = 4;
    localparam int DW  = 32;
    typedef struct packed {
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
    } beat_t;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    in_valid;
    logic [NCH*DW-1:0] in_data;
    logic              in_ready;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [DW-1:0]     cfg_offset;
    logic [NCH-1:0]    out_valid;
    logic [NCH*DW-1:0] out_data;
    logic              out_ready;
    logic              sleep_en;
    logic              sleep_req;
    logic              busy;
    int                n_chk = 0;
    int                n_fail = 0;
    beat_t             exp_q[$];
    logic [DW-1:0]     mdl_off [NCH];
    always #5 clk = ~clk;
    mvt_multich_datapath #(
        .NUM_CH(NCH), .DATA_W(DW), .PIPE_STAGES(2), .IDLE_THRESH(16), .WAKE_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_offset (cfg_offset),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sleep_en   (sleep_en),
        .sleep_req  (sleep_req),
        .busy       (busy)
    );
    function automatic void chk(string name, logic [NCH*DW-1:0] act, logic [NCH*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction
    function automatic logic [NCH*DW-1:0] lmask(logic [NCH-1:0] v);
        logic [NCH*DW-1:0] m;
        for (int k = 0; k < NCH; k++) m[k*DW +: DW] = {DW{v[k]}};
        return m;
    endfunction
    function automatic logic [NCH*DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction
    // Reference model: every accepted beat yields one output beat of input + current offset, in order.
    task automatic cyc();
        beat_t e;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            for (int k = 0; k < NCH; k++) mdl_off[k] = '0;
        end else begin
            if (|in_valid && in_ready) begin
                e.v = in_valid;
                for (int k = 0; k < NCH; k++) e.d[k*DW +: DW] = in_data[k*DW +: DW] + mdl_off[k];
                exp_q.push_back(e);
            end
            if (cfg_we) mdl_off[cfg_ch] = cfg_offset;
        end
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n && |out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {{(NCH*DW-NCH){1'b0}}, out_valid}, '0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_valid", {{(NCH*DW-NCH){1'b0}}, out_valid}, {{(NCH*DW-NCH){1'b0}}, e.v});
                chk("sb_data", out_data & lmask(e.v), e.d & lmask(e.v));
            end
        end
    end
    task automatic go_sleep();
        in_valid  = 4'b0001;
        in_data   = rnd();
        out_ready = 1'b1;
        #1 chk("pre_sleep_ready", in_ready, 1);
        cyc();
        in_valid = '0;
        for (int k = 0; k < 10 && busy; k++) cyc();
        chk("pre_sleep_busy", busy, 0);
        for (int k = 0; k < 15; k++) cyc();
        chk("sleep_not_yet", sleep_req, 0);
        cyc();
        chk("sleep_req", sleep_req, 1);
        chk("sleep_in_ready", in_ready, 0);
    endtask
    initial begin
        logic [NCH*DW-1:0] d;
        logic [NCH*DW-1:0] bd [4];
        logic [NCH-1:0]    bm [4];
        int                sent;
        logic              acc;
        logic              seen;
        rst_n = 1'b0; in_valid = '0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0;
        cfg_offset = '0; out_ready = 1'b1; sleep_en = 1'b0;
        cyc();
        cyc();
        chk("rst_out_valid", {{(NCH*DW-NCH){1'b0}}, out_valid}, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_sleep_req", sleep_req, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_offset = 32'd100;
        cyc();
        cfg_we = 1'b0;
        d = rnd(); d[2*DW +: DW] = 32'd5;
        in_valid = 4'b0100; in_data = d;
        cyc();
        in_valid = '0;
        chk("lat_stage1", {{(NCH*DW-NCH){1'b0}}, out_valid}, '0);
        cyc();
        chk("lat_valid", {{(NCH*DW-NCH){1'b0}}, out_valid}, {{(NCH*DW-NCH){1'b0}}, 4'b0100});
        chk("lat_data", {{(NCH*DW-DW){1'b0}}, out_data[2*DW +: DW]}, 105);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_offset = 32'd2;
        cyc();
        d = rnd(); d[DW-1:0] = 32'hFFFF_FFFF;
        in_valid = 4'b0001; in_data = d; cfg_offset = 32'd7;
        cyc();
        cfg_we = 1'b0;
        cyc();
        in_valid = '0;
        chk("wrap_data", {{(NCH*DW-DW){1'b0}}, out_data[DW-1:0]}, 1);
        cyc();
        chk("new_offset_data", {{(NCH*DW-DW){1'b0}}, out_data[DW-1:0]}, 6);
        bm[0] = 4'b0001; bm[1] = 4'b1010; bm[2] = 4'b1111; bm[3] = 4'b0110;
        for (int k = 0; k < 4; k++) bd[k] = rnd();
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 4) ? bm[sent] : '0;
            in_data   = bd[sent % 4];
            #1;
            if (c >= 3 && c <= 5) chk("bp_in_ready", in_ready, 0);
            acc = in_ready;
            cyc();
            if (acc && sent < 4) sent++;
        end
        chk("bp_all_sent", sent, 4);
        for (int c = 0; c < 300; c++) begin
            in_valid   = NCH'($urandom_range(0, 15));
            in_data    = rnd();
            out_ready  = ($urandom_range(0, 3) != 0);
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_offset = $urandom();
            #1;
            chk("rand_in_ready", in_ready, !(|out_valid) || out_ready);
            cyc();
        end
        cfg_we = 1'b0;
        sleep_en = 1'b1;
        go_sleep();
        in_valid = 4'b0010; in_data = rnd();
        cyc();
        chk("wake_sleep_req", sleep_req, 0);
        chk("wake_ready_1", in_ready, 0);
        cyc();
        chk("wake_ready_2", in_ready, 0);
        cyc();
        chk("wake_run_ready", in_ready, 1);
        cyc();
        in_valid = '0;
        chk("wake_beat_stage1", {{(NCH*DW-NCH){1'b0}}, out_valid}, '0);
        cyc();
        chk("wake_beat_out", {{(NCH*DW-NCH){1'b0}}, out_valid}, {{(NCH*DW-NCH){1'b0}}, 4'b0010});
        sleep_en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            seen = seen | sleep_req;
        end
        chk("sleep_blocked", seen, 0);
        sleep_en = 1'b1;
        go_sleep();
        sleep_en = 1'b0;
        cyc();
        chk("exit_sleep_req", sleep_req, 0);
        chk("exit_ready_1", in_ready, 0);
        cyc();
        chk("exit_ready_2", in_ready, 0);
        cyc();
        chk("exit_run_ready", in_ready, 1);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_offset = 32'd55;
        cyc();
        cfg_we = 1'b0;
        in_valid = 4'b1111; in_data = rnd();
        cyc();
        in_data = rnd();
        cyc();
        in_valid = '0;
        rst_n = 1'b0;
        cyc();
        chk("midrst_out_valid", {{(NCH*DW-NCH){1'b0}}, out_valid}, '0);
        chk("midrst_sleep_req", sleep_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        d = rnd();
        in_valid = 4'b1111; in_data = d;
        cyc();
        in_valid = '0;
        cyc();
        chk("midrst_offsets", out_data, d);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        chk("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
